rc4_ksa_fsm: RTL and testbench
==============================

Name: rc4_ksa_fsm

Overview:
Parametrised RC4 key-scheduling engine, the generalised successor of the fixed 24-bit-key task2a FSM. It drives a single-port synchronous S-box RAM. It optionally fills S[k]=k first, then runs the KSA swap loop using a key of KEY_BYTES bytes. It sits between the key-search controller (start/finish handshake) and the S-box memory; the PRGA/decrypt stage starts after finish.

Parameters:
KEY_BYTES, 3, key length in bytes (1..32); key byte k = secret_key[8*(KEY_BYTES-1-k) +: 8], so byte 0 is the MSB byte.
SBOX_AW, 8, S-box address width; depth N = 2**SBOX_AW; data width = SBOX_AW.
DO_INIT, 1, 1 = run the fill phase S[k]=k before the KSA; 0 = KSA only, with the S-box assumed pre-filled.

Ports:
clock  in  1  system clock, rising-edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
secret_key  in  8*KEY_BYTES  key; latched on the edge that accepts start
q  in  SBOX_AW  RAM read data; valid the cycle after the address is presented
address  out  SBOX_AW  RAM address
data  out  SBOX_AW  RAM write data
wren  out  1  RAM write enable
busy  out  1  high from the start-accept edge until entering DONE
finish  out  1  high in DONE; held until the next start is accepted

Behaviour:
- Reset (async, reset_n=0): state=IDLE; i=0, j=0, si=0, sj=0; address=0, data=0, wren=0, busy=0, finish=0. The outputs go low immediately and do not wait for a clock edge.
- Reset mid-operation: the sequence is aborted and RAM contents are undefined. After reset_n rises, the block waits for a new start.
- States: IDLE, FILL, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, DONE. All outputs are registered or decoded from state and registers only, with no combinational path from q to outputs.
- IDLE/DONE + start=1: latch the key, clear i=0 and j=0, set busy=1 and finish=0. Next state is FILL if DO_INIT=1, otherwise RD_I.
- start while busy: ignored; latched key unchanged.
- FILL: address=i, data=i, wren=1. i increments mod N. When i==N-1, go to RD_I with i wrapping to 0. Duration is exactly N cycles.
- RD_I: address=i, wren=0.
- CAP_I: si<=q; j<=(j+q+key[i mod KEY_BYTES]) mod N.
  - Addition is SBOX_AW-bit wrap-around.
  - The key byte is zero-extended or truncated to SBOX_AW bits.
  - The key index is a counter that wraps at KEY_BYTES, not a divider.
- RD_J: address=j (the new j), wren=0.
- CAP_J: sj<=q.
- WR_I: address=i, data=sj, wren=1.
- WR_J: address=j, data=si, wren=1. If i==N-1, go to DONE; else i<=i+1 and go to RD_I.
- i==j: both writes store si; the S-box is unchanged at that index (correct RC4 behaviour, no special case).
- Latency: start-accept edge to finish=1 is N*(6+DO_INIT) cycles, i.e. 1792 for the defaults and 1536 with DO_INIT=0.
- wren is high only in FILL, WR_I and WR_J. At most one RAM access is made per cycle.
- DONE: wren=0, busy=0, finish=1. A start in DONE restarts the run directly with a new key; finish drops on the accept edge.

Test Plan:
- Defaults, secret_key=24'h000000, start pulse of 1 cycle:
  - FILL writes addr k with data k for k=0..255.
  - First KSA accesses: rd 0, rd 0, wr(0,0), wr(0,0); i=1: rd 1, rd 1 (j=1); i=2: j=3, writes (2,3) then (3,2).
  - finish rises exactly 1792 cycles after the accept edge.
- secret_key=24'h000102 with a behavioural RAM model: the final S-box matches a software RC4 KSA reference for all 256 entries.
- KEY_BYTES=5, SBOX_AW=4, DO_INIT=0, pre-filled RAM:
  - The key index wraps 0..4 repeatedly.
  - The final S matches the model.
  - finish rises after 96 cycles.
- start asserted at cycle 500 of a run: ignored, and the final result still matches the original key. A second start in DONE with a new key: finish drops on the next edge and the new result matches.
- reset_n pulled low for 3 cycles mid-KSA (cycle 900): wren, busy and finish fall with no clock edge. The next start gives a correct full run of 1792 cycles.
- Check j wrap-around with key 24'hFFFFFF: j exceeds 255 and wraps mod 256, and the result matches the model.

Source files
------------

// File: rtl/rc4_ksa_fsm.sv
// RC4 key-scheduling engine driving a single-port synchronous S-box RAM.
// Optionally fills S[k]=k, then runs the KSA swap loop with a KEY_BYTES-byte key.
module rc4_ksa_fsm #(
  parameter int KEY_BYTES = 3,
  parameter int SBOX_AW   = 8,
  parameter int DO_INIT   = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [SBOX_AW-1:0]     q,
  output logic [SBOX_AW-1:0]     address,
  output logic [SBOX_AW-1:0]     data,
  output logic                   wren,
  output logic                   busy,
  output logic                   finish,
  output logic [3:0]             dbg_state
);

  // Handshake: start is sampled only in IDLE/DONE; busy is high from the accept
  // edge until DONE; finish is high in DONE and drops on the next accept edge.
  typedef enum logic [3:0] {
    IDLE, FILL, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, DONE
  } state_t;

  localparam int                KI_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [SBOX_AW-1:0] LAST   = '1;
  localparam logic [SBOX_AW-1:0] ONE    = SBOX_AW'(1);
  localparam logic [KI_W-1:0]    KI_LAST = KI_W'(KEY_BYTES - 1);
  localparam logic [KI_W-1:0]    KI_ONE  = KI_W'(1);

  state_t                 state;
  logic [8*KEY_BYTES-1:0] key;
  logic [SBOX_AW-1:0]     i, j, si, sj;
  logic [KI_W-1:0]        kidx;
  logic [7:0]             key_arr [KEY_BYTES];
  logic [7:0]             key_byte;
  logic [SBOX_AW-1:0]     key_ext;
  logic [SBOX_AW-1:0]     j_next;

  // Byte 0 of the key is the most significant byte of secret_key.
  for (genvar k = 0; k < KEY_BYTES; k++) begin : g_key
    assign key_arr[k] = key[8*(KEY_BYTES-1-k) +: 8];
  end

  always_comb begin
    key_byte = key_arr[kidx];
    key_ext  = SBOX_AW'(key_byte);
    j_next   = j + q + key_ext;
  end

  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      key     <= '0;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      kidx    <= '0;
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      busy    <= 1'b0;
      finish  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            key     <= secret_key;
            i       <= '0;
            j       <= '0;
            kidx    <= '0;
            busy    <= 1'b1;
            finish  <= 1'b0;
            address <= '0;
            data    <= '0;
            if (DO_INIT != 0) begin
              state <= FILL;
              wren  <= 1'b1;
            end else begin
              state <= RD_I;
              wren  <= 1'b0;
            end
          end
        end
        FILL: begin
          if (i == LAST) begin
            i       <= '0;
            address <= '0;
            wren    <= 1'b0;
            state   <= RD_I;
          end else begin
            i       <= i + ONE;
            address <= i + ONE;
            data    <= i + ONE;
          end
        end
        RD_I: state <= CAP_I;
        CAP_I: begin
          // The new j is also the read address for S[j] in the next cycle.
          si      <= q;
          j       <= j_next;
          address <= j_next;
          kidx    <= (kidx == KI_LAST) ? '0 : kidx + KI_ONE;
          state   <= RD_J;
        end
        RD_J: state <= CAP_J;
        CAP_J: begin
          sj      <= q;
          address <= i;
          data    <= q;
          wren    <= 1'b1;
          state   <= WR_I;
        end
        WR_I: begin
          address <= j;
          data    <= si;
          state   <= WR_J;
        end
        WR_J: begin
          wren <= 1'b0;
          if (i == LAST) begin
            busy   <= 1'b0;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            i       <= i + ONE;
            address <= i + ONE;
            state   <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_wren_states: assert property (@(posedge clock) disable iff (!reset_n)
    wren |-> (state == FILL || state == WR_I || state == WR_J));
  a_busy_finish: assert property (@(posedge clock) disable iff (!reset_n)
    !(busy && finish));

endmodule

// File: tb/tb_rc4_ksa_fsm.sv
// Self-checking bench for rc4_ksa_fsm: default config plus a small 16-entry,
// 5-byte-key, no-fill instance, each with a behavioural synchronous RAM.
module tb_rc4_ksa_fsm;

  localparam int N  = 256;
  localparam int NS = 16;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  // ---------------- default instance ----------------
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  q, address, data;
  logic        wren, busy, finish;
  logic [3:0]  dbg_state;
  logic [7:0]  mem [N];

  rc4_ksa_fsm dut (
    .clock(clock), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .q(q), .address(address), .data(data), .wren(wren), .busy(busy),
    .finish(finish), .dbg_state(dbg_state)
  );

  always @(posedge clock) begin
    if (wren) mem[address] <= data;
    q <= mem[address];
  end

  // ---------------- small instance ----------------
  logic        start_s = 1'b0;
  logic [39:0] secret_key_s = '0;
  logic [3:0]  q_s, address_s, data_s;
  logic        wren_s, busy_s, finish_s;
  logic [3:0]  dbg_state_s;
  logic [3:0]  mem_s [NS];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0, pre_data = '0;

  rc4_ksa_fsm #(.KEY_BYTES(5), .SBOX_AW(4), .DO_INIT(0)) dut_s (
    .clock(clock), .reset_n(reset_n), .start(start_s), .secret_key(secret_key_s),
    .q(q_s), .address(address_s), .data(data_s), .wren(wren_s), .busy(busy_s),
    .finish(finish_s), .dbg_state(dbg_state_s)
  );

  always @(posedge clock) begin
    if (wren_s) mem_s[address_s] <= data_s;
    else if (pre_we) mem_s[pre_addr] <= pre_data;
    q_s <= mem_s[address_s];
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp_s_q[$];
  logic [17:0] trace_q[$];   // {kind, addr, data}: 0 = no write, 1 = read, 2 = write
  int         ms [N];

  // Plain software RC4 KSA.
  task automatic model_ksa(input int n, input int kb, input logic [255:0] key, input bit perm_init);
    int j, kv, t;
    logic [255:0] sh;
    for (int k = 0; k < n; k++) ms[k] = perm_init ? (k * 7 + 3) % n : k;
    j = 0;
    for (int i = 0; i < n; i++) begin
      sh = key >> (8 * (kb - 1 - (i % kb)));
      kv = int'(sh[7:0]) % n;
      j  = (j + ms[i] + kv) % n;
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
    end
  endtask

  task automatic push_default(input logic [23:0] key);
    model_ksa(N, 3, 256'(key), 1'b0);
    for (int k = 0; k < N; k++) exp_q.push_back(8'(ms[k]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [23:0] key);
    @(negedge clock);
    secret_key = key;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b0;
    while (finish !== 1'b1) begin
      @(posedge clock);
      #1;
      cycles++;
      if (cycles > 4000) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start_s(input logic [39:0] key);
    @(negedge clock);
    secret_key_s = key;
    start_s = 1'b1;
    @(posedge clock);
    #1;
    start_s = 1'b0;
  endtask

  task automatic wait_finish_s(output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b0;
    while (finish_s !== 1'b1) begin
      @(posedge clock);
      #1;
      cycles++;
      if (cycles > 1000) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic prefill_s();
    for (int k = 0; k < NS; k++) begin
      @(negedge clock);
      pre_we   = 1'b1;
      pre_addr = 4'(k);
      pre_data = 4'((k * 7 + 3) % NS);
    end
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_checks++; if (address !== 8'h00) begin n_fail++; $display("FAIL reset_address: got %h expected 00", address); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
    n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", wren); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b expected 0", finish); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_zero_key_trace();
    int cyc;
    logic [17:0] e, obs;
    for (int k = 0; k < N; k++) trace_q.push_back({2'd2, 8'(k), 8'(k)});
    // i=0: j=0; i=1: j=1; i=2: j=3, swap S[2]=2 and S[3]=3
    trace_q.push_back({2'd1, 8'd0, 8'd0}); trace_q.push_back(18'd0);
    trace_q.push_back({2'd1, 8'd0, 8'd0}); trace_q.push_back(18'd0);
    trace_q.push_back({2'd2, 8'd0, 8'd0}); trace_q.push_back({2'd2, 8'd0, 8'd0});
    trace_q.push_back({2'd1, 8'd1, 8'd0}); trace_q.push_back(18'd0);
    trace_q.push_back({2'd1, 8'd1, 8'd0}); trace_q.push_back(18'd0);
    trace_q.push_back({2'd2, 8'd1, 8'd1}); trace_q.push_back({2'd2, 8'd1, 8'd1});
    trace_q.push_back({2'd1, 8'd2, 8'd0}); trace_q.push_back(18'd0);
    trace_q.push_back({2'd1, 8'd3, 8'd0}); trace_q.push_back(18'd0);
    trace_q.push_back({2'd2, 8'd2, 8'd3}); trace_q.push_back({2'd2, 8'd3, 8'd2});
    push_default(24'h000000);
    pulse_start(24'h000000);
    cyc = 0;
    while (cyc <= 4000) begin
      if (trace_q.size() > 0) begin
        e = trace_q.pop_front();
        obs = {wren ? 2'd2 : ((e[17:16] == 2'd1) ? 2'd1 : 2'd0),
               (e[17:16] != 2'd0) ? address : 8'd0,
               (e[17:16] == 2'd2) ? data : 8'd0};
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL trace_cycle%0d: got %h expected %h", cyc, obs, e);
        end
      end
      if (finish === 1'b1) break;
      @(posedge clock);
      #1;
      cyc++;
    end
    n_checks++; if (cyc != 1792) begin n_fail++; $display("FAIL latency_zero: got %0d expected 1792", cyc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b expected 0", busy); end
    for (int k = 0; k < N; k++) begin
      logic [7:0] x;
      x = exp_q.pop_front();
      n_checks++;
      if (mem[k] !== x) begin n_fail++; $display("FAIL sbox_zero[%0d]: got %h expected %h", k, mem[k], x); end
    end
  endtask

  task automatic test_key(input logic [23:0] key);
    int cyc;
    bit to;
    push_default(key);
    pulse_start(key);
    wait_finish(cyc, to);
    n_checks++; if (to || cyc != 1792) begin n_fail++; $display("FAIL latency_key_%h: got %0d expected 1792", key, cyc); end
    for (int k = 0; k < N; k++) begin
      logic [7:0] x;
      x = exp_q.pop_front();
      n_checks++;
      if (mem[k] !== x) begin n_fail++; $display("FAIL sbox_key_%h[%0d]: got %h expected %h", key, k, mem[k], x); end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    bit to;
    push_default(24'h1A2B3C);
    pulse_start(24'h1A2B3C);
    repeat (499) @(posedge clock);
    pulse_start(24'hC3B2A1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_ignore_start: got %b expected 1", busy); end
    wait_finish(cyc, to);
    n_checks++; if (to || cyc != 1292) begin n_fail++; $display("FAIL latency_busy: got %0d expected 1292", cyc); end
    for (int k = 0; k < N; k++) begin
      logic [7:0] x;
      x = exp_q.pop_front();
      n_checks++;
      if (mem[k] !== x) begin n_fail++; $display("FAIL sbox_busy[%0d]: got %h expected %h", k, mem[k], x); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    push_default(24'h5EED01);
    pulse_start(24'h5EED01);
    n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL finish_drop: got %b expected 0", finish); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_restart: got %b expected 1", busy); end
    wait_finish(cyc, to);
    n_checks++; if (to || cyc != 1792) begin n_fail++; $display("FAIL latency_b2b: got %0d expected 1792", cyc); end
    for (int k = 0; k < N; k++) begin
      logic [7:0] x;
      x = exp_q.pop_front();
      n_checks++;
      if (mem[k] !== x) begin n_fail++; $display("FAIL sbox_b2b[%0d]: got %h expected %h", k, mem[k], x); end
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(24'h777777);
    repeat (902) @(posedge clock);
    #3;
    n_checks++; if (wren !== 1'b1) begin n_fail++; $display("FAIL wren_before_reset: got %b expected 1", wren); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL async_wren: got %b expected 0", wren); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b expected 0", busy); end
    n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL async_finish: got %b expected 0", finish); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    n_checks++; if ({busy, finish, wren} !== 3'b000) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {busy, finish, wren}); end
    test_key(24'h777777);
  endtask

  task automatic test_small_config(input logic [39:0] key);
    int cyc;
    bit to;
    prefill_s();
    model_ksa(NS, 5, 256'(key), 1'b1);
    for (int k = 0; k < NS; k++) exp_s_q.push_back(4'(ms[k]));
    pulse_start_s(key);
    wait_finish_s(cyc, to);
    n_checks++; if (to || cyc != 96) begin n_fail++; $display("FAIL latency_small: got %0d expected 96", cyc); end
    for (int k = 0; k < NS; k++) begin
      logic [3:0] x;
      x = exp_s_q.pop_front();
      n_checks++;
      if (mem_s[k] !== x) begin n_fail++; $display("FAIL sbox_small[%0d]: got %h expected %h", k, mem_s[k], x); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero_key_trace();
    test_key(24'h000102);
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_key(24'hFFFFFF);
    test_key(24'($urandom_range(0, 32'h00FF_FFFF)));
    test_small_config(40'h01_23_45_67_89);
    test_small_config({8'($urandom_range(0, 255)), 32'($urandom)});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
